// File: rtl/spi_host.sv
// Bit-serial SPI host for the register-file slave: serialises a wr/rd/addr/wdata frame and returns the read word.
// Optional macro SPI_HOST_ADDR_CHECK_EN rejects out-of-range addresses with a one-cycle err pulse.
module spi_host #(
  parameter int REGISTERS = 8,
  parameter int SWORD     = 8,
  parameter int ADDR_W    = $clog2(REGISTERS),
  parameter int GAP_CYC   = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              wr,
  input  logic              rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [SWORD-1:0]  wdata,
  output logic              busy,
  output logic              done,
  output logic [SWORD-1:0]  rdata,
  output logic              err,
  output logic              CEB,
  output logic              DATA,
  input  logic              DOUT
);

  localparam int TXW = 2 + ADDR_W + SWORD;
  localparam int CW  = $clog2(SWORD + GAP_CYC + ADDR_W + 2) + 1;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, WDAT, RDAT, GAP} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [TXW-1:0]  tx_shift;
  logic [SWORD-1:0] rx_shift;
  logic            rd_q;
  logic            addr_bad;

`ifdef SPI_HOST_ADDR_CHECK_EN
  localparam logic [ADDR_W:0] ADDR_LIM = (ADDR_W+1)'(REGISTERS);
  assign addr_bad = ({1'b0, addr} >= ADDR_LIM);
`else
  assign addr_bad = 1'b0;
  assign err      = 1'b0;
`endif

  // Rising-edge sequencer; the last GAP cycle also accepts a new request so frames can run back to back.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= '0;
      tx_shift <= '0;
      rd_q     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rdata    <= '0;
`ifdef SPI_HOST_ADDR_CHECK_EN
      err      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef SPI_HOST_ADDR_CHECK_EN
      err  <= 1'b0;
`endif
      case (state)
        IDLE, GAP: begin
          if (state == GAP && cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (start && !addr_bad) begin
            state    <= CMD;
            cnt      <= CW'(1);
            tx_shift <= {wr, rd, addr, {SWORD{wr}} & wdata};
            rd_q     <= rd;
            busy     <= 1'b1;
          end else begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
`ifdef SPI_HOST_ADDR_CHECK_EN
            if (start) err <= 1'b1;
`endif
          end
        end
        CMD: begin
          tx_shift <= tx_shift << 1;
          if (cnt == '0) begin
            state <= ADDR;
            cnt   <= CW'(ADDR_W - 1);
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ADDR: begin
          tx_shift <= tx_shift << 1;
          if (cnt == '0) begin
            state <= WDAT;
            cnt   <= CW'(SWORD - 1);
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        WDAT: begin
          tx_shift <= tx_shift << 1;
          if (cnt == '0) begin
            // One turnaround cycle precedes the SWORD capture cycles.
            state <= RDAT;
            cnt   <= CW'(SWORD);
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RDAT: begin
          if (cnt == '0) begin
            state <= GAP;
            cnt   <= CW'(GAP_CYC - 1);
            done  <= 1'b1;
            if (rd_q) rdata <= rx_shift;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Falling-edge pins give the slave half a cycle of setup and hold around its rising-edge sampling.
  always_ff @(negedge CLK or posedge RST) begin
    if (RST) begin
      CEB      <= 1'b1;
      DATA     <= 1'b0;
      rx_shift <= '0;
    end else begin
      CEB  <= 1'b1;
      DATA <= 1'b0;
      case (state)
        CMD, ADDR, WDAT: begin
          CEB  <= 1'b0;
          DATA <= tx_shift[TXW-1];
        end
        RDAT: begin
          CEB <= (cnt == '0);
          if (cnt != CW'(SWORD)) rx_shift <= {rx_shift[SWORD-2:0], DOUT};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_host.sv
// Directed bench for spi_host with a behavioural register-file slave whose read bus returns the register number.
module tb_spi_host;

`ifdef SPI_HOST_ADDR_CHECK_EN
  localparam int REGS = 6;
`else
  localparam int REGS = 8;
`endif
  localparam int SWORD   = 8;
  localparam int ADDR_W  = 3;
  localparam int TX_BITS = 2 + ADDR_W + SWORD;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic start = 1'b0, wr = 1'b0, rd = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [SWORD-1:0]  wdata = '0;
  logic busy, done, err, CEB, DATA;
  logic [SWORD-1:0] rdata;
  logic DOUT = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [SWORD-1:0] slave_regs [0:7] = '{default: 8'h00};
  logic [SWORD-1:0] exp_regs [0:7];
  logic [TX_BITS-1:0] rx_frame = '0;
  logic [TX_BITS-1:0] s_shift = '0;
  logic [ADDR_W-1:0]  s_addr = '0;
  logic [SWORD-1:0]   rd_word;
  int s_cnt = 0;
  logic [SWORD-1:0] tb_rdata;

  spi_host #(.REGISTERS(REGS), .SWORD(SWORD), .GAP_CYC(2)) dut (
    .CLK(CLK), .RST(RST), .start(start), .wr(wr), .rd(rd), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .err(err), .CEB(CEB), .DATA(DATA), .DOUT(DOUT)
  );

  always #5 CLK = ~CLK;

  // Slave model: samples DATA on rising edges, commits writes after the last write bit, then drives the read word.
  always @(posedge CLK) begin
    if (CEB) begin
      s_cnt = 0;
      DOUT  = 1'b0;
    end else begin
      if (s_cnt < TX_BITS) begin
        s_shift = {s_shift[TX_BITS-2:0], DATA};
        if (s_cnt == TX_BITS - 1) begin
          rx_frame = s_shift;
          s_addr   = s_shift[SWORD+ADDR_W-1:SWORD];
          if (s_shift[TX_BITS-1]) slave_regs[s_addr] = s_shift[SWORD-1:0];
        end
        DOUT = 1'b0;
      end else if (s_cnt < TX_BITS + SWORD) begin
        rd_word = {5'b0, s_addr};
        DOUT = rd_word[SWORD-1-(s_cnt-TX_BITS)];
      end else begin
        DOUT = 1'b0;
      end
      s_cnt++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One frame from request to end of gap; pulse_cyc>0 raises start again just before that edge.
  task automatic applyStimulus(input logic f_wr, input logic f_rd, input logic [ADDR_W-1:0] f_addr,
                               input logic [SWORD-1:0] f_data, input int pulse_cyc);
    logic [TX_BITS-1:0] exp_bits;
    int done_cnt, done_at, busy_low_at, err_cnt;
    exp_bits = {f_wr, f_rd, f_addr, f_wr ? f_data : 8'h00};
    if (f_rd) tb_rdata = {5'b0, f_addr};
    if (f_wr) exp_regs[f_addr] = f_data;
    @(posedge CLK); #1;
    start = 1'b1; wr = f_wr; rd = f_rd; addr = f_addr; wdata = f_data;
    @(posedge CLK); #1;
    start = 1'b0; wr = ~f_wr; rd = ~f_rd; addr = ~f_addr; wdata = ~f_data;
    checkOutput("busy_e0", busy, 1);
    done_cnt = 0; done_at = -1; busy_low_at = -1; err_cnt = 0;
    for (int j = 1; j <= 30; j++) begin
      start = (j == pulse_cyc);
      @(posedge CLK); #1;
      if (done) begin done_cnt++; done_at = j; end
      if (err) err_cnt++;
      if (!busy && busy_low_at < 0) busy_low_at = j;
      if (j == 21) checkOutput("ceb_low_e21", CEB, 0);
      if (j == 22) checkOutput("ceb_high_e22", CEB, 1);
    end
    start = 1'b0;
    checkOutput("done_count", done_cnt, 1);
    checkOutput("done_edge", done_at, 22);
    checkOutput("busy_fall_edge", busy_low_at, 24);
    checkOutput("err_none", err_cnt, 0);
    checkOutput("data_stream", rx_frame, exp_bits);
    checkOutput("rdata", rdata, tb_rdata);
    checkOutput("slave_reg", slave_regs[f_addr], exp_regs[f_addr]);
  endtask

  initial begin
    int done_cnt, next_idx, ceb_low;
    for (int i = 0; i < 8; i++) exp_regs[i] = 8'h00;
    tb_rdata = '0;

    #12;
    checkOutput("rst_ceb", CEB, 1);
    checkOutput("rst_data", DATA, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_rdata", rdata, 0);
    checkOutput("rst_err", err, 0);
    @(posedge CLK); #1;
    RST = 1'b0;

    applyStimulus(1'b1, 1'b1, 3'd3, 8'hA5, 0);
    applyStimulus(1'b0, 1'b1, 3'd5, 8'h5A, 0);
    applyStimulus(1'b1, 1'b0, 3'd6, 8'hC3, 5);
    applyStimulus(1'b0, 1'b0, 3'd1, 8'hFF, 0);

    // Back-to-back frames with start held high.
    @(posedge CLK); #1;
    start = 1'b1; wr = 1'b1; rd = 1'b1; addr = 3'd0; wdata = 8'h10;
    @(posedge CLK); #1;
    addr = 3'd1; wdata = 8'h11;
    for (int f = 0; f < 8; f++) begin
      done_cnt = 0;
      for (int j = 1; j <= 24; j++) begin
        @(posedge CLK); #1;
        if (done) done_cnt++;
        if (j == 22) begin
          checkOutput("b2b_done", done, 1);
          checkOutput("b2b_rdata", rdata, f);
        end
        if (j == 23) checkOutput("b2b_reg", slave_regs[f], 8'h10 + f);
        if (j >= 22) checkOutput("b2b_gap_ceb", CEB, 1);
        if (j == 24) begin
          checkOutput("b2b_busy", busy, (f < 7) ? 1 : 0);
          next_idx = f + 2;
          if (next_idx < 8) begin
            addr = next_idx[2:0]; wdata = 8'h10 + next_idx[7:0];
          end else begin
            start = 1'b0;
          end
        end
      end
      checkOutput("b2b_done_count", done_cnt, 1);
    end
    for (int i = 0; i < 8; i++) exp_regs[i] = 8'h10 + i[7:0];
    tb_rdata = 8'h07;

    // Reset in the middle of the read phase.
    @(posedge CLK); #1;
    start = 1'b1; wr = 1'b1; rd = 1'b1; addr = 3'd2; wdata = 8'h3C;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (15) @(posedge CLK);
    #2; RST = 1'b1; #1;
    checkOutput("midrst_ceb", CEB, 1);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_done", done, 0);
    @(posedge CLK); #1;
    RST = 1'b0;
    exp_regs[2] = 8'h3C;
    tb_rdata = '0;
    done_cnt = 0;
    for (int j = 0; j < 30; j++) begin
      @(posedge CLK); #1;
      if (done) done_cnt++;
    end
    checkOutput("midrst_no_done", done_cnt, 0);
    checkOutput("midrst_rdata", rdata, 0);
    applyStimulus(1'b1, 1'b1, 3'd2, 8'h96, 0);

`ifdef SPI_HOST_ADDR_CHECK_EN
    @(posedge CLK); #1;
    start = 1'b1; wr = 1'b1; rd = 1'b1; addr = 3'd7; wdata = 8'h77;
    @(posedge CLK); #1;
    start = 1'b0;
    checkOutput("reject_err", err, 1);
    checkOutput("reject_busy", busy, 0);
    ceb_low = 0; done_cnt = 0;
    for (int j = 0; j < 30; j++) begin
      @(posedge CLK); #1;
      if (!CEB) ceb_low++;
      if (done) done_cnt++;
      if (err) ceb_low++;
    end
    checkOutput("reject_quiet", ceb_low, 0);
    checkOutput("reject_no_done", done_cnt, 0);
`else
    ceb_low = 0;
    applyStimulus(1'b1, 1'b1, 3'd7, 8'h77, 0);
    checkOutput("no_check_err", err, ceb_low);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
